rf_wport_arbiter: RTL and testbench

Shares the single register-file write port between the in-order WB stage and the multi-cycle mul/div unit (MDU), which retires results out of pipeline order. MDU results are held in a small FIFO and drained into free write-port cycles. WB keeps priority, with an optional starvation guard. The block also exposes pending-write hit signals so ID can stall on buffered MDU destinations, and drives the debug trace from whichever source wins the port.

---
 rtl/rf_wport_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - RF write-port arbiter between WB and a buffered MDU result FIFO
// Optional feature macro: RF_ARB_STARVE_GUARD_EN (starvation guard that stalls WB for the FIFO head)
module rf_wport_arbiter #(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_waddr,
    input  logic [31:0] md_wdata,
    input  logic [31:0] md_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    output logic        pend_hit1,
    output logic        pend_hit2,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    localparam int AW = $clog2(BUF_DEPTH);

    logic [4:0]  buf_waddr [BUF_DEPTH];
    logic [31:0] buf_wdata [BUF_DEPTH];
    logic [31:0] buf_pc    [BUF_DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic        full, empty, push, pop, wb_grant;
    logic [BUF_DEPTH-1:0] entry_valid;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count    = wptr - rptr;
    assign md_ready = resetn & ~full;
    // Results for r0 are acknowledged to the MDU but never occupy a slot.
    assign push     = md_valid & md_ready & (md_waddr != 5'd0);
    assign wb_grant = resetn & wb_valid & wb_ready;
    assign pop      = resetn & ~wb_grant & ~empty;

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign wb_ready = ~resetn | (starve_cnt != 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!resetn)
            starve_cnt <= 4'd0;
        else if (empty || pop)
            starve_cnt <= 4'd0;
        else if (starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign wb_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                buf_waddr[wptr[AW-1:0]] <= md_waddr;
                buf_wdata[wptr[AW-1:0]] <= md_wdata;
                buf_pc[wptr[AW-1:0]]    <= md_pc;
                wptr <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < BUF_DEPTH; i++)
            entry_valid[i] = ({1'b0, i[AW-1:0] - rptr[AW-1:0]} < count);
    end

    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (entry_valid[i] && buf_waddr[i] == id_raddr1) pend_hit1 = 1'b1;
            if (entry_valid[i] && buf_waddr[i] == id_raddr2) pend_hit2 = 1'b1;
        end
        if (!resetn || id_raddr1 == 5'd0) pend_hit1 = 1'b0;
        if (!resetn || id_raddr2 == 5'd0) pend_hit2 = 1'b0;
    end

    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        rf_wdata    = 32'd0;
        debug_wb_pc = 32'd0;
        if (wb_grant) begin
            rf_we       = wb_we;
            rf_waddr    = wb_waddr;
            rf_wdata    = wb_wdata;
            debug_wb_pc = wb_pc;
        end else if (pop) begin
            rf_we       = 1'b1;
            rf_waddr    = buf_waddr[rptr[AW-1:0]];
            rf_wdata    = buf_wdata[rptr[AW-1:0]];
            debug_wb_pc = buf_pc[rptr[AW-1:0]];
        end
    end

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed self-checking bench for rf_wport_arbiter
module tb_rf_wport_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid, wb_ready, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, wb_pc;
    logic        md_valid, md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata, md_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  id_raddr1, id_raddr2;
    logic        pend_hit1, pend_hit2;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr),
        .md_wdata(md_wdata), .md_pc(md_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 0; wb_valid = 1; wb_we = 1; wb_waddr = 5'd4; wb_wdata = 32'h55; wb_pc = 32'h80;
        md_valid = 1; md_waddr = 5'd3; md_wdata = 32'h1; md_pc = 32'h2;
        id_raddr1 = 5'd3; id_raddr2 = 5'd0;

        for (int c = 0; c < 3; c++) begin
            next_cycle(); settle();
            chk("rst_md_ready", md_ready, 0);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_dbg_wen", debug_wb_rf_wen, 0);
        end
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_dbg_pc", debug_wb_pc, 0);
        chk("rst_pend_hit1", pend_hit1, 0);

        next_cycle(); resetn = 1; wb_valid = 0; md_valid = 0; settle();
        chk("post_rst_md_ready", md_ready, 1);
        chk("post_rst_rf_we", rf_we, 0);

        // Single MDU push drains on the next idle cycle.
        next_cycle(); md_valid = 1; md_waddr = 5'd5; md_wdata = 32'hDEADBEEF; md_pc = 32'hBFC00010;
        id_raddr1 = 5'd5; settle();
        chk("push5_rf_we_c0", rf_we, 0);
        chk("push5_hit_c0", pend_hit1, 0);
        next_cycle(); md_valid = 0; settle();
        chk("pop5_rf_we", rf_we, 1);
        chk("pop5_waddr", rf_waddr, 5);
        chk("pop5_wdata", rf_wdata, 32'hDEADBEEF);
        chk("pop5_pc", debug_wb_pc, 32'hBFC00010);
        chk("pop5_dbg_wen", debug_wb_rf_wen, 4'hF);
        chk("pop5_dbg_wnum", debug_wb_rf_wnum, 5);
        chk("pop5_hit_head", pend_hit1, 1);
        next_cycle(); settle();
        chk("empty_rf_we", rf_we, 0);
        chk("empty_hit", pend_hit1, 0);

        // Fill the FIFO while WB holds the port.
        next_cycle(); wb_valid = 1; wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'h11; wb_pc = 32'h100;
        md_valid = 1; md_waddr = 5'd7; md_wdata = 32'h70; md_pc = 32'h700; settle();
        chk("fill7_md_ready", md_ready, 1);
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_waddr", rf_waddr, 2);
        chk("wb_rf_wdata", rf_wdata, 32'h11);
        chk("wb_dbg_pc", debug_wb_pc, 32'h100);
        next_cycle(); md_waddr = 5'd9; md_wdata = 32'h90; md_pc = 32'h900; settle();
        chk("fill9_md_ready", md_ready, 1);
        chk("fill9_wb_ready", wb_ready, 1);
        next_cycle(); md_waddr = 5'd11; id_raddr1 = 5'd9; id_raddr2 = 5'd7; settle();
        chk("full_md_ready", md_ready, 0);
        chk("full_hit1_r9", pend_hit1, 1);
        chk("full_hit2_r7", pend_hit2, 1);
        chk("full_wb_waddr", rf_waddr, 2);
        id_raddr1 = 5'd0; id_raddr2 = 5'd11; settle();
        chk("full_hit1_r0", pend_hit1, 0);
        chk("full_hit2_r11", pend_hit2, 0);
        next_cycle(); wb_valid = 0; md_valid = 0; settle();
        chk("drain7_waddr", rf_waddr, 7);
        chk("drain7_pc", debug_wb_pc, 32'h700);
        next_cycle(); settle();
        chk("drain9_waddr", rf_waddr, 9);
        chk("drain9_wdata", rf_wdata, 32'h90);
        next_cycle(); settle();
        chk("drained_rf_we", rf_we, 0);

        // One buffered entry against continuous WB traffic.
        next_cycle(); md_valid = 1; md_waddr = 5'd12; md_wdata = 32'h00C0FFEE; md_pc = 32'h200;
        id_raddr1 = 5'd12; settle();
        next_cycle(); md_valid = 0; wb_valid = 1; wb_waddr = 5'd3; wb_wdata = 32'h33; wb_pc = 32'h300;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("starve_wb_ready", wb_ready, 1);
            chk("starve_wb_waddr", rf_waddr, 3);
            chk("starve_hit", pend_hit1, 1);
            next_cycle();
        end
        settle();
`ifdef RF_ARB_STARVE_GUARD_EN
        chk("guard_wb_ready_low", wb_ready, 0);
        chk("guard_rf_we", rf_we, 1);
        chk("guard_waddr", rf_waddr, 12);
        chk("guard_wdata", rf_wdata, 32'h00C0FFEE);
        chk("guard_pc", debug_wb_pc, 32'h200);
        next_cycle(); settle();
        chk("guard_wb_ready_back", wb_ready, 1);
        chk("guard_wb_waddr_back", rf_waddr, 3);
        chk("guard_hit_clear", pend_hit1, 0);
        next_cycle(); wb_valid = 0; settle();
        chk("guard_idle_rf_we", rf_we, 0);
`else
        chk("noguard_wb_ready", wb_ready, 1);
        chk("noguard_wb_waddr", rf_waddr, 3);
        next_cycle(); settle();
        chk("noguard_wb_ready2", wb_ready, 1);
        chk("noguard_hit_held", pend_hit1, 1);
        next_cycle(); wb_valid = 0; settle();
        chk("noguard_drain_we", rf_we, 1);
        chk("noguard_drain_waddr", rf_waddr, 12);
        chk("noguard_drain_pc", debug_wb_pc, 32'h200);
        next_cycle(); settle();
        chk("noguard_idle_rf_we", rf_we, 0);
`endif

        // r0 results are acknowledged but dropped.
        next_cycle(); wb_valid = 0; md_valid = 1; md_waddr = 5'd0; md_wdata = 32'h1234; md_pc = 32'h400; settle();
        chk("r0_md_ready", md_ready, 1);
        next_cycle(); md_valid = 0; settle();
        chk("r0_no_write", rf_we, 0);
        chk("r0_wdata_zero", rf_wdata, 0);

        // Reset with two entries buffered discards them.
        next_cycle(); wb_valid = 1; md_valid = 1; md_waddr = 5'd20; md_wdata = 32'h20; id_raddr1 = 5'd20; settle();
        next_cycle(); md_waddr = 5'd21; md_wdata = 32'h21; settle();
        chk("rst2_push21_ready", md_ready, 1);
        next_cycle(); md_valid = 0; settle();
        chk("rst2_full", md_ready, 0);
        chk("rst2_hit_before", pend_hit1, 1);
        next_cycle(); resetn = 0; wb_valid = 0; settle();
        chk("rst2_rf_we_in_rst", rf_we, 0);
        chk("rst2_hit_in_rst", pend_hit1, 0);
        next_cycle(); resetn = 1; settle();
        chk("rst2_no_stale_we", rf_we, 0);
        chk("rst2_md_ready", md_ready, 1);
        chk("rst2_hit_after", pend_hit1, 0);
        next_cycle(); settle();
        chk("rst2_still_idle", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
